// File: rtl/t_seq_packer_pkg.sv
// Shared constants, state encoding and packet helper for the T-sequence packer.
// The packet layout matches the SRAM controller's i_t port.
package t_seq_packer_pkg;

  localparam int T_PER_WORD = 7;
  localparam int CHAR_W     = 2;
  localparam int PAYLOAD_W  = T_PER_WORD * CHAR_W;
  localparam int T_PKT_W    = 18;
  localparam int VALID_BIT  = 17;
  localparam int CNT_MSB    = 16;
  localparam int CNT_LSB    = 14;
  localparam int FILL_W     = CNT_MSB - CNT_LSB + 1;

  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(T_PER_WORD);

  typedef enum logic [1:0] {
    NT_A = 2'd0,
    NT_C = 2'd1,
    NT_G = 2'd2,
    NT_T = 2'd3
  } nt_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [T_PKT_W-1:0] make_packet(input logic [FILL_W-1:0]    cnt,
                                                     input logic [PAYLOAD_W-1:0] payload);
    logic [T_PKT_W-1:0] pkt;
    pkt                   = '0;
    pkt[VALID_BIT]        = 1'b1;
    pkt[CNT_MSB:CNT_LSB]  = cnt;
    pkt[PAYLOAD_W-1:0]    = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/t_seq_packer_accum.sv
// Seven-slot character accumulator. Exposes the payload and fill count as they
// would look with the incoming character merged, so the top can close a packet on acceptance.
module t_char_accum
  import t_seq_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic                 i_last,
  input  logic [CHAR_W-1:0]    i_char,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic [FILL_W-1:0]    o_fill_n
);

  logic [PAYLOAD_W-1:0] r_data;
  logic [FILL_W-1:0]    r_fill;
  logic [3:0]           w_slot_lsb;

  // Character k lands at bits 13-2k : 12-2k, so the first character is MSB-aligned.
  assign w_slot_lsb = 4'(PAYLOAD_W - CHAR_W) - 4'({r_fill, 1'b0});
  assign o_payload  = r_data | (PAYLOAD_W'(i_char) << w_slot_lsb);
  assign o_fill_n   = r_fill + 1'b1;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_data <= '0;
      r_fill <= '0;
    end else if (i_push) begin
      if (i_last || (o_fill_n == FULL_FILL)) begin
        r_data <= '0;
        r_fill <= '0;
      end else begin
        r_data <= o_payload;
        r_fill <= o_fill_n;
      end
    end
  end

endmodule

// File: rtl/t_seq_packer.sv
// Packs a 2-bit character stream into 18-bit T packets for the SRAM controller,
// issues the start pulse and enforces the SRAM word budget.
module t_seq_packer
  import t_seq_packer_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_LOG   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_char_valid,
  input  logic [CHAR_W-1:0]  i_char,
  input  logic               i_char_last,
  output logic               o_char_ready,
  input  logic               i_sram_busy,
  output logic               o_start_read_t,
  output logic [T_PKT_W-1:0] o_t,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_truncated
);

  localparam logic [CNT_LOG-1:0] LAST_PKT = CNT_LOG'(MAX_WORDS - 1);

  state_e               r_state;
  state_e               w_next_state;
  logic [CNT_LOG-1:0]   r_pkt_cnt;
  logic [T_PKT_W-1:0]   r_t;
  logic                 r_start_read_t;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_truncated;
  logic                 r_char_ready;
  logic                 w_accept;
  logic                 w_start_ok;
  logic                 w_push;
  logic                 w_cnt_inc;
  logic                 w_truncate;
  logic [T_PKT_W-1:0]   w_pkt;
  logic [PAYLOAD_W-1:0] w_payload;
  logic [FILL_W-1:0]    w_fill_n;

  assign w_accept   = i_char_valid & r_char_ready;
  assign w_start_ok = (r_state == S_IDLE) & i_start & ~i_sram_busy;
  assign w_push     = w_accept & (r_state == S_COLLECT);

  t_char_accum u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_start_ok),
    .i_push    (w_push),
    .i_last    (i_char_last),
    .i_char    (i_char),
    .o_payload (w_payload),
    .o_fill_n  (w_fill_n)
  );

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pkt        = '0;
    w_cnt_inc    = 1'b0;
    w_truncate   = 1'b0;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_next_state = S_ARM;
      S_ARM:     w_next_state = S_COLLECT;
      S_COLLECT: begin
        if (w_accept) begin
          if (i_char_last) begin
            w_pkt        = make_packet(w_fill_n, w_payload);
            w_next_state = S_DONE;
          end else if (w_fill_n == FULL_FILL) begin
            w_pkt = make_packet('0, w_payload);
            // The budget is spent but T continues: swallow the rest.
            if (r_pkt_cnt == LAST_PKT) begin
              w_truncate   = 1'b1;
              w_next_state = S_DRAIN;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end
      end
      S_DRAIN:   if (w_accept && i_char_last) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pkt_cnt      <= '0;
      r_t            <= '0;
      r_start_read_t <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_truncated    <= 1'b0;
      r_char_ready   <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_t            <= w_pkt;
      r_start_read_t <= (w_next_state == S_ARM);
      r_busy         <= (w_next_state == S_ARM) || (w_next_state == S_COLLECT) ||
                        (w_next_state == S_DRAIN);
      r_done         <= (w_next_state == S_DONE);
      r_char_ready   <= (w_next_state == S_COLLECT) || (w_next_state == S_DRAIN);
      if (w_start_ok)     r_pkt_cnt <= '0;
      else if (w_cnt_inc) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_start_ok)      r_truncated <= 1'b0;
      else if (w_truncate) r_truncated <= 1'b1;
    end
  end

  assign o_t            = r_t;
  assign o_start_read_t = r_start_read_t;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_truncated    = r_truncated;
  assign o_char_ready   = r_char_ready;

endmodule

// File: tb/tb_t_seq_packer.sv
// Randomized bench for t_seq_packer against a list-level packing model,
// run with a 4-word budget so truncation is reachable.
module tb_t_seq_packer;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start = 1'b0;
  logic        i_char_valid = 1'b0;
  logic [1:0]  i_char = 2'd0;
  logic        i_char_last = 1'b0;
  logic        o_char_ready;
  logic        i_sram_busy = 1'b0;
  logic        o_start_read_t;
  logic [17:0] o_t;
  logic        o_busy;
  logic        o_done;
  logic        o_truncated;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_edge;

  logic [1:0]  t_chars[$];
  logic [17:0] exp_pkt[$];
  int          exp_close[$];
  bit          exp_trunc;

  logic [17:0] mon_pkt[$];
  int          mon_pkt_cyc[$];
  int          mon_start_cyc[$];
  logic [19:0] mon_start_snap[$];
  int          mon_done_cyc[$];
  int          anomaly = 0;

  t_seq_packer #(.MAX_WORDS(MAXW), .CNT_LOG(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (i_start),
    .i_char_valid   (i_char_valid),
    .i_char         (i_char),
    .i_char_last    (i_char_last),
    .o_char_ready   (o_char_ready),
    .i_sram_busy    (i_sram_busy),
    .o_start_read_t (o_start_read_t),
    .o_t            (o_t),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_truncated    (o_truncated)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_t[17]) begin
        mon_pkt.push_back(o_t);
        mon_pkt_cyc.push_back(cyc);
      end else if (o_t != 18'd0) begin
        anomaly++;
      end
      if (o_start_read_t) begin
        mon_start_cyc.push_back(cyc);
        mon_start_snap.push_back({o_busy, o_truncated, o_t});
      end
      if (o_done) mon_done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    mon_pkt.delete();
    mon_pkt_cyc.delete();
    mon_start_cyc.delete();
    mon_start_snap.delete();
    mon_done_cyc.delete();
    anomaly = 0;
  endtask

  // Split the character list into groups of seven; stop at the last character
  // or once the word budget is used up by full packets.
  task automatic build_model(input int n);
    logic [13:0] payload;
    int slot;
    int pkts;
    exp_pkt.delete();
    exp_close.delete();
    exp_trunc = 1'b0;
    payload   = '0;
    slot      = 0;
    pkts      = 0;
    for (int i = 0; i < n; i++) begin
      payload[13-2*slot -: 2] = t_chars[i];
      slot++;
      if (i == n - 1) begin
        exp_pkt.push_back({1'b1, 3'(slot), payload});
        exp_close.push_back(i);
        break;
      end
      if (slot == 7) begin
        exp_pkt.push_back({1'b1, 3'b000, payload});
        exp_close.push_back(i);
        pkts++;
        slot    = 0;
        payload = '0;
        if (pkts == MAXW) begin
          exp_trunc = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic run_load(input int n, input bit rnd_gap, input bit inject);
    int acc_edge[64];
    int waits;
    bit ok;
    bit acc;
    foreach (acc_edge[k]) acc_edge[k] = -1;
    build_model(n);
    clear_mon();
    i_start = 1'b1;
    @(negedge clk);
    start_edge = cyc + 1;
    @(posedge clk); #1;
    i_start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      if (rnd_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      i_char_valid = 1'b1;
      i_char       = t_chars[i];
      i_char_last  = (i == n - 1);
      i_start      = inject && (i == 2);
      acc   = 1'b0;
      waits = 0;
      while (!acc && ok) begin
        @(negedge clk);
        acc = o_char_ready;
        if (acc) acc_edge[i] = cyc + 1;
        @(posedge clk); #1;
        if (!acc) begin
          waits++;
          if (waits > 20) begin
            check("ready_timeout", 32'd0, 32'd1);
            ok = 1'b0;
          end
        end
      end
      i_char_valid = 1'b0;
      i_char_last  = 1'b0;
      i_start      = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("pkt_count", mon_pkt.size(), exp_pkt.size());
    for (int k = 0; k < exp_pkt.size() && k < mon_pkt.size(); k++) begin
      check("pkt_value", mon_pkt[k], exp_pkt[k]);
      check("pkt_latency", mon_pkt_cyc[k], acc_edge[exp_close[k]]);
    end
    check("start_count", mon_start_cyc.size(), 1);
    if (mon_start_cyc.size() > 0) begin
      check("start_edge", mon_start_cyc[0], start_edge);
      check("start_snapshot", mon_start_snap[0], {1'b1, 1'b0, 18'd0});
    end
    check("done_count", mon_done_cyc.size(), 1);
    if (mon_done_cyc.size() > 0) check("done_edge", mon_done_cyc[0], acc_edge[n-1]);
    check("truncated", o_truncated, exp_trunc);
    check("busy_after", o_busy, 1'b0);
    check("o_t_idle_glitch", anomaly, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", {o_t, o_start_read_t, o_busy, o_done, o_truncated, o_char_ready}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Characters offered in IDLE are never accepted.
    i_char_valid = 1'b1;
    i_char       = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ready", o_char_ready, 1'b0);
      check("idle_outputs", {o_t, o_start_read_t, o_busy, o_done}, 32'd0);
    end
    @(posedge clk); #1;
    i_char_valid = 1'b0;

    // Start while the SRAM controller is busy is ignored.
    clear_mon();
    i_sram_busy = 1'b1;
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_pulse", mon_start_cyc.size(), 0);
    check("busy_start_busy", o_busy, 1'b0);
    i_sram_busy = 1'b0;

    t_chars = '{2'd0, 2'd1, 2'd2, 2'd3};
    build_model(4);
    check("model_example", exp_pkt[0], 18'b1_100_00011011_000000);
    run_load(4, 1'b0, 1'b0);

    t_chars.delete();
    repeat (14) t_chars.push_back(2'd2);
    run_load(14, 1'b0, 1'b1);

    t_chars.delete();
    for (int k = 0; k < 8; k++) t_chars.push_back(2'($urandom_range(0, 3)));
    run_load(8, 1'b0, 1'b0);

    t_chars.delete();
    for (int k = 0; k < 35; k++) t_chars.push_back(2'($urandom_range(0, 3)));
    run_load(35, 1'b0, 1'b0);

    t_chars = '{2'd3};
    run_load(1, 1'b0, 1'b0);

    t_chars.delete();
    for (int k = 0; k < 28; k++) t_chars.push_back(2'($urandom_range(0, 3)));
    run_load(28, 1'b1, 1'b0);

    t_chars.delete();
    for (int k = 0; k < 29; k++) t_chars.push_back(2'($urandom_range(0, 3)));
    run_load(29, 1'b0, 1'b0);

    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(1, 40);
      t_chars.delete();
      for (int k = 0; k < n; k++) t_chars.push_back(2'($urandom_range(0, 3)));
      run_load(n, 1'b1, 1'($urandom_range(0, 1)));
    end

    // Reset while a full packet is on o_t aborts the load at once.
    clear_mon();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start      = 1'b0;
    i_char_valid = 1'b1;
    i_char       = 2'd1;
    begin
      int accepted;
      accepted = 0;
      for (int k = 0; k < 20 && accepted < 7; k++) begin
        @(negedge clk);
        if (o_char_ready) accepted++;
        @(posedge clk); #1;
      end
    end
    check("pre_reset_pkt", o_t[17], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {o_t, o_start_read_t, o_busy, o_done, o_truncated, o_char_ready}, 32'd0);
    clear_mon();
    i_char_last = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_pkts", mon_pkt.size(), 0);
    check("post_reset_done", mon_done_cyc.size(), 0);
    check("post_reset_state", {o_busy, o_char_ready}, 2'b00);
    i_char_valid = 1'b0;
    i_char_last  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
